muldiv_sequencer: RTL and testbench

Multi-cycle sequencer for the signed multiply and divide operations selected by ALU_funct codes 5'b00100 (mult) and 5'b01001 (div). It sits beside the ALU and owns the HI/LO result registers. On a start request it runs a 32-iteration shift-add multiply or restoring divide, and holds `stall` high so the core freezes the PC and pipeline until the result is committed.

---
 rtl/muldiv_sequencer.sv | 223 ++++++++++++++++++++++
 tb/tb_muldiv_sequencer.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/muldiv_sequencer.sv
// Sequencer for signed 32-iteration shift-add multiply and restoring divide.
// It owns the HI/LO result registers and stalls the core while an operation runs.
module muldiv_sequencer #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [4:0]       ALU_funct,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             stall,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo,
    output logic             div_by_zero
);

    localparam logic [4:0] FUNCT_MULT = 5'b00100;
    localparam logic [4:0] FUNCT_DIV  = 5'b01001;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_CALC = 2'd1;
    localparam logic [1:0] ST_SIGN = 2'd2;
    localparam logic [1:0] ST_DONE = 2'd3;

    localparam int            CW       = $clog2(WIDTH);
    localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);

    // Magnitude in WIDTH+1 bits so the most negative operand stays representable.
    function automatic logic [WIDTH:0] magnitude(input logic [WIDTH-1:0] x);
        logic [WIDTH:0] ext;
        ext = {x[WIDTH-1], x};
        if (x[WIDTH-1]) begin
            magnitude = ~ext + {{WIDTH{1'b0}}, 1'b1};
        end else begin
            magnitude = ext;
        end
    endfunction

    function automatic logic [WIDTH-1:0] negate_w(input logic [WIDTH-1:0] x);
        negate_w = ~x + {{(WIDTH-1){1'b0}}, 1'b1};
    endfunction

    logic [1:0]       state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             is_div_q, is_div_d;
    logic             zdiv_q, zdiv_d;
    logic             pneg_q, pneg_d;
    logic             rneg_q, rneg_d;
    logic [WIDTH:0]   acc_q, acc_d;
    logic [WIDTH-1:0] low_q, low_d;
    logic [WIDTH:0]   opnd_q, opnd_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic [WIDTH-1:0] hi_q, hi_d;
    logic [WIDTH-1:0] lo_q, lo_d;
    logic             dbz_q, dbz_d;

    logic               funct_valid_s;
    logic               accept_s;
    logic [WIDTH:0]     mag_a_s;
    logic [WIDTH:0]     mag_b_s;
    logic [WIDTH:0]     mul_sum_s;
    logic [WIDTH:0]     div_shift_s;
    logic [WIDTH+1:0]   div_trial_s;
    logic [2*WIDTH-1:0] prod_s;
    logic [2*WIDTH-1:0] prod_neg_s;

    assign funct_valid_s = (ALU_funct == FUNCT_MULT) || (ALU_funct == FUNCT_DIV);
    assign accept_s      = start && funct_valid_s && (state_q == ST_IDLE);
    assign mag_a_s       = magnitude(a);
    assign mag_b_s       = magnitude(b);

    // acc holds the upper product half for mult and the partial remainder for div.
    assign mul_sum_s   = acc_q + (low_q[0] ? opnd_q : {(WIDTH+1){1'b0}});
    assign div_shift_s = {acc_q[WIDTH-1:0], low_q[WIDTH-1]};
    assign div_trial_s = {1'b0, div_shift_s} - {1'b0, opnd_q};
    assign prod_s      = {acc_q[WIDTH-1:0], low_q};
    assign prod_neg_s  = ~prod_s + {{(2*WIDTH-1){1'b0}}, 1'b1};

    // Next-state and datapath update for the sequencer.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        is_div_d = is_div_q;
        zdiv_d   = zdiv_q;
        pneg_d   = pneg_q;
        rneg_d   = rneg_q;
        acc_d    = acc_q;
        low_d    = low_q;
        opnd_d   = opnd_q;
        busy_d   = busy_q;
        done_d   = 1'b0;
        hi_d     = hi_q;
        lo_d     = lo_q;
        dbz_d    = dbz_q;
        case (state_q)
            ST_IDLE: begin
                if (accept_s) begin
                    is_div_d = (ALU_funct == FUNCT_DIV);
                    cnt_d    = {CW{1'b0}};
                    dbz_d    = 1'b0;
                    busy_d   = 1'b1;
                    pneg_d   = a[WIDTH-1] ^ b[WIDTH-1];
                    rneg_d   = a[WIDTH-1];
                    acc_d    = {(WIDTH+1){1'b0}};
                    if (ALU_funct == FUNCT_DIV) begin
                        if (b == {WIDTH{1'b0}}) begin
                            // Zero divisor skips CALC; the raw dividend is parked for HI.
                            zdiv_d  = 1'b1;
                            low_d   = a;
                            opnd_d  = {(WIDTH+1){1'b0}};
                            state_d = ST_SIGN;
                        end else begin
                            zdiv_d  = 1'b0;
                            low_d   = mag_a_s[WIDTH-1:0];
                            opnd_d  = mag_b_s;
                            state_d = ST_CALC;
                        end
                    end else begin
                        zdiv_d  = 1'b0;
                        low_d   = mag_b_s[WIDTH-1:0];
                        opnd_d  = mag_a_s;
                        state_d = ST_CALC;
                    end
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_CALC: begin
                if (is_div_q) begin
                    if (!div_trial_s[WIDTH+1]) begin
                        acc_d = div_trial_s[WIDTH:0];
                        low_d = {low_q[WIDTH-2:0], 1'b1};
                    end else begin
                        acc_d = div_shift_s;
                        low_d = {low_q[WIDTH-2:0], 1'b0};
                    end
                end else begin
                    acc_d = {1'b0, mul_sum_s[WIDTH:1]};
                    low_d = {mul_sum_s[0], low_q[WIDTH-1:1]};
                end
                if (cnt_q == CNT_LAST) begin
                    cnt_d   = {CW{1'b0}};
                    state_d = ST_SIGN;
                end else begin
                    cnt_d   = cnt_q + CNT_ONE;
                    state_d = ST_CALC;
                end
            end
            ST_SIGN: begin
                if (zdiv_q) begin
                    hi_d  = low_q;
                    lo_d  = {WIDTH{1'b1}};
                    dbz_d = 1'b1;
                end else if (is_div_q) begin
                    lo_d = pneg_q ? negate_w(low_q) : low_q;
                    hi_d = rneg_q ? negate_w(acc_q[WIDTH-1:0]) : acc_q[WIDTH-1:0];
                end else begin
                    {hi_d, lo_d} = pneg_q ? prod_neg_s : prod_s;
                end
                busy_d  = 1'b0;
                done_d  = 1'b1;
                state_d = ST_DONE;
            end
            ST_DONE: begin
                busy_d  = 1'b0;
                state_d = ST_IDLE;
            end
            default: begin
                busy_d  = 1'b0;
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and result registers with asynchronous clear.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= ST_IDLE;
            cnt_q    <= {CW{1'b0}};
            is_div_q <= 1'b0;
            zdiv_q   <= 1'b0;
            pneg_q   <= 1'b0;
            rneg_q   <= 1'b0;
            acc_q    <= {(WIDTH+1){1'b0}};
            low_q    <= {WIDTH{1'b0}};
            opnd_q   <= {(WIDTH+1){1'b0}};
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            hi_q     <= {WIDTH{1'b0}};
            lo_q     <= {WIDTH{1'b0}};
            dbz_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            is_div_q <= is_div_d;
            zdiv_q   <= zdiv_d;
            pneg_q   <= pneg_d;
            rneg_q   <= rneg_d;
            acc_q    <= acc_d;
            low_q    <= low_d;
            opnd_q   <= opnd_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            hi_q     <= hi_d;
            lo_q     <= lo_d;
            dbz_q    <= dbz_d;
        end
    end

    // Stall covers the accept cycle combinationally, then follows busy.
    assign stall       = accept_s | busy_q;
    assign busy        = busy_q;
    assign done        = done_q;
    assign hi          = hi_q;
    assign lo          = lo_q;
    assign div_by_zero = dbz_q;

endmodule

// File: tb/tb_muldiv_sequencer.sv
// Self-checking bench: directed vector table, hand sequences for corner cases,
// and random operations compared against a plain-arithmetic reference model.
module tb_muldiv_sequencer;

    localparam logic [4:0] F_MULT = 5'b00100;
    localparam logic [4:0] F_DIV  = 5'b01001;

    logic        clk;
    logic        rst_n;
    logic        start_s;
    logic [4:0]  funct_s;
    logic [31:0] a_s;
    logic [31:0] b_s;
    logic        busy_s;
    logic        stall_s;
    logic        done_s;
    logic [31:0] hi_s;
    logic [31:0] lo_s;
    logic        dbz_s;

    int checks = 0;
    int errors = 0;

    muldiv_sequencer #(.WIDTH(32)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start_s),
        .ALU_funct  (funct_s),
        .a          (a_s),
        .b          (b_s),
        .busy       (busy_s),
        .stall      (stall_s),
        .done       (done_s),
        .hi         (hi_s),
        .lo         (lo_s),
        .div_by_zero(dbz_s)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [4:0]  f;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] hi;
        logic [31:0] lo;
        logic        dbz;
        int          lat;
    } vec_t;

    vec_t vecs[8];

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    // Reference: signed arithmetic on 64-bit integers, truncating division.
    task automatic model(input logic [4:0] f, input logic [31:0] x, input logic [31:0] y,
                         output logic [31:0] h, output logic [31:0] l, output logic z,
                         output int lat);
        longint sx, sy, p, q, r;
        sx = longint'($signed(x));
        sy = longint'($signed(y));
        z = 1'b0;
        lat = 34;
        if (f == F_MULT) begin
            p = sx * sy;
            h = p[63:32];
            l = p[31:0];
        end else if (y == 32'h0) begin
            h = x;
            l = 32'hFFFFFFFF;
            z = 1'b1;
            lat = 2;
        end else begin
            q = sx / sy;
            r = sx % sy;
            h = r[31:0];
            l = q[31:0];
        end
    endtask

    // Issue one operation; returns the cycle (after the accept edge) in which done
    // was seen and how many cycles busy was high. inject>0 raises a new mult start
    // in that cycle of the running operation.
    task automatic do_op(input logic [4:0] f, input logic [31:0] ia, input logic [31:0] ib,
                         input int inject, output int lat, output int bcnt);
        @(negedge clk);
        start_s = 1'b1; funct_s = f; a_s = ia; b_s = ib;
        #1 chk("stall_accept", {63'd0, stall_s}, 64'd1);
        @(posedge clk);
        @(negedge clk);
        start_s = 1'b0; funct_s = 5'd0; a_s = $urandom; b_s = $urandom;
        lat = 1;
        bcnt = 0;
        while (!done_s && lat < 200) begin
            if (busy_s) bcnt++;
            if (lat == inject) begin
                start_s = 1'b1; funct_s = F_MULT;
                #1 chk("stall_busy", {63'd0, stall_s}, 64'd1);
            end else begin
                start_s = 1'b0;
            end
            @(negedge clk);
            lat++;
        end
        start_s = 1'b0;
        #1;
        chk("done_seen", {63'd0, done_s}, 64'd1);
        chk("busy_in_done", {63'd0, busy_s}, 64'd0);
        chk("stall_in_done", {63'd0, stall_s}, 64'd0);
    endtask

    task automatic check_result(input string tag, input logic [31:0] eh, input logic [31:0] el,
                                input logic ez, input int elat, input int lat, input int bcnt);
        chk({tag, "_hi"}, {32'd0, hi_s}, {32'd0, eh});
        chk({tag, "_lo"}, {32'd0, lo_s}, {32'd0, el});
        chk({tag, "_dbz"}, {63'd0, dbz_s}, {63'd0, ez});
        chk({tag, "_latency"}, 64'(lat), 64'(elat));
        chk({tag, "_busy_cycles"}, 64'(bcnt), 64'(elat - 1));
    endtask

    initial begin
        logic [31:0] eh, el, ra, rb;
        logic [4:0]  rf;
        logic        ez;
        int          elat, lat, bcnt;

        vecs[0] = '{F_MULT, 32'd7,          32'hFFFFFFFD, 32'hFFFFFFFF, 32'hFFFFFFEB, 1'b0, 34};
        vecs[1] = '{F_MULT, 32'h80000000,   32'h80000000, 32'h40000000, 32'h00000000, 1'b0, 34};
        vecs[2] = '{F_DIV,  32'hFFFFFFF9,   32'd2,        32'hFFFFFFFF, 32'hFFFFFFFD, 1'b0, 34};
        vecs[3] = '{F_DIV,  32'h12345678,   32'd0,        32'h12345678, 32'hFFFFFFFF, 1'b1, 2};
        vecs[4] = '{F_MULT, 32'd3,          32'd4,        32'h00000000, 32'h0000000C, 1'b0, 34};
        vecs[5] = '{F_DIV,  32'h80000000,   32'hFFFFFFFF, 32'h00000000, 32'h80000000, 1'b0, 34};
        vecs[6] = '{F_DIV,  32'd100,        32'd7,        32'h00000002, 32'h0000000E, 1'b0, 34};
        vecs[7] = '{F_MULT, 32'hFFFFFFFF,   32'hFFFFFFFF, 32'h00000000, 32'h00000001, 1'b0, 34};

        rst_n = 1'b0; start_s = 1'b0; funct_s = 5'd0; a_s = 32'd0; b_s = 32'd0;
        repeat (3) @(negedge clk);
        chk("rst_busy", {63'd0, busy_s}, 64'd0);
        chk("rst_done", {63'd0, done_s}, 64'd0);
        chk("rst_hilo", {hi_s, lo_s}, 64'd0);
        chk("rst_dbz", {63'd0, dbz_s}, 64'd0);
        rst_n = 1'b1;

        for (int i = 0; i < 8; i++) begin
            do_op(vecs[i].f, vecs[i].a, vecs[i].b, 0, lat, bcnt);
            check_result($sformatf("vec%0d", i), vecs[i].hi, vecs[i].lo, vecs[i].dbz,
                         vecs[i].lat, lat, bcnt);
            if (i == 0) begin
                // A start raised during the DONE cycle must be ignored.
                start_s = 1'b1; funct_s = F_MULT; a_s = 32'd9; b_s = 32'd9;
                @(posedge clk);
                #1 start_s = 1'b0;
                @(negedge clk);
                chk("done_cycle_start_ignored", {63'd0, busy_s}, 64'd0);
            end
        end

        // Invalid funct: no stall, no busy, results held.
        @(negedge clk);
        start_s = 1'b1; funct_s = 5'b00010; a_s = 32'd55; b_s = 32'd66;
        #1 chk("invalid_stall", {63'd0, stall_s}, 64'd0);
        @(negedge clk);
        start_s = 1'b0;
        chk("invalid_busy", {63'd0, busy_s}, 64'd0);
        chk("invalid_hilo_held", {hi_s, lo_s}, {32'h00000000, 32'h00000001});

        // Start during a running mult is ignored.
        do_op(F_MULT, 32'd1000, 32'hFFFFFF00, 5, lat, bcnt);
        check_result("inject", 32'hFFFFFFFF, 32'hFFFC1800, 1'b0, 34, lat, bcnt);

        for (int i = 0; i < 40; i++) begin
            rf = ($urandom_range(0, 1) == 0) ? F_MULT : F_DIV;
            ra = $urandom;
            rb = $urandom;
            case ($urandom_range(0, 5))
                0: rb = 32'd0;
                1: rb = 32'($urandom_range(1, 20));
                2: ra = 32'h80000000;
                3: rb = 32'hFFFFFFFF;
                default: ;
            endcase
            model(rf, ra, rb, eh, el, ez, elat);
            do_op(rf, ra, rb, 0, lat, bcnt);
            check_result($sformatf("rand%0d", i), eh, el, ez, elat, lat, bcnt);
        end

        // Reset in the middle of CALC aborts and clears everything.
        @(negedge clk);
        start_s = 1'b1; funct_s = F_MULT; a_s = 32'h11111111; b_s = 32'h22222222;
        @(posedge clk);
        @(negedge clk);
        start_s = 1'b0;
        repeat (9) @(negedge clk);
        chk("pre_reset_busy", {63'd0, busy_s}, 64'd1);
        rst_n = 1'b0;
        #1;
        chk("midrst_busy", {63'd0, busy_s}, 64'd0);
        chk("midrst_stall", {63'd0, stall_s}, 64'd0);
        chk("midrst_done", {63'd0, done_s}, 64'd0);
        chk("midrst_hilo", {hi_s, lo_s}, 64'd0);
        chk("midrst_dbz", {63'd0, dbz_s}, 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        do_op(F_MULT, 32'd5, 32'd6, 0, lat, bcnt);
        check_result("post_reset", 32'd0, 32'd30, 1'b0, 34, lat, bcnt);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
